// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction ROM port, pipeline control inputs and the
// registered decode-facing outputs, seen from the fetch unit (master) or its environment (slave).
interface ifetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [8:0]  imem_adrs;
    logic [31:0] imem_dout;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_valid;

    modport master (
        input  stall, redirect, redirect_pc, halt, imem_dout,
        output imem_adrs, if_instr, if_pc, if_pc4, if_valid
    );

    modport slave (
        output stall, redirect, redirect_pc, halt, imem_dout,
        input  imem_adrs, if_instr, if_pc, if_pc4, if_valid
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: pc register plus BOOT/RUN/HALT control feeding one
// registered instruction slot to decode, with redirect, stall and halt handling.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    ifetch_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            if_instr_q <= NOP_WORD;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_valid_q <= if_valid_d;
        end
    end

    // In RUN the priority is halt, then redirect, then stall, then a normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_valid_d = if_valid_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    state_d    = HALT;
                    if_instr_d = NOP_WORD;
                    if_valid_d = 1'b0;
                end else if (bus.redirect) begin
                    pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
                    if_instr_d = NOP_WORD;
                    if_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    pc_d       = pc_plus4;
                    if_instr_d = bus.imem_dout;
                    if_pc_d    = pc_q;
                    if_pc4_d   = pc_plus4;
                    if_valid_d = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // The ROM address depends on pc alone so the ROM read path stays off the control inputs.
    assign bus.imem_adrs = pc_q[10:2];
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_pc4    = if_pc4_q;
    assign bus.if_valid  = if_valid_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a synthetic ROM returns a tagged word per address
// and each step compares the fetch outputs against hand-computed values.
module tb_ifetch;

    logic clk;
    logic rst;
    int   check_count;
    int   pass_count;

    ifetch_if bus ();

    ifetch #(
        .RESET_PC(32'h0040_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [31:0] rom_word(input logic [8:0] adrs);
        return 32'hA5A5_0000 | {23'd0, adrs};
    endfunction

    assign bus.imem_dout = rom_word(bus.imem_adrs);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic stall, input logic redirect,
                                 input logic [31:0] redirect_pc, input logic halt);
        bus.stall       = stall;
        bus.redirect    = redirect;
        bus.redirect_pc = redirect_pc;
        bus.halt        = halt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFetch(input string tag, input logic [31:0] pc);
        checkOutput({tag, " if_valid"}, {31'd0, bus.if_valid}, 32'd1);
        checkOutput({tag, " if_pc"}, bus.if_pc, pc);
        checkOutput({tag, " if_pc4"}, bus.if_pc4, pc + 32'd4);
        checkOutput({tag, " if_instr"}, bus.if_instr, rom_word(pc[10:2]));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " if_valid"}, {31'd0, bus.if_valid}, 32'd0);
        checkOutput({tag, " if_instr"}, bus.if_instr, 32'd0);
        checkOutput({tag, " if_pc"}, bus.if_pc, 32'd0);
        checkOutput({tag, " if_pc4"}, bus.if_pc4, 32'd0);
        checkOutput({tag, " imem_adrs"}, {23'd0, bus.imem_adrs}, 32'h000);
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

        // Reset values appear without any clock edge
        #1 rst = 1'b1;
        #1;
        checkReset("reset");

        step();
        rst = 1'b0;

        // Boot cycle, then one-cycle fetch latency
        step();
        checkOutput("boot if_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("boot imem_adrs", {23'd0, bus.imem_adrs}, 32'h000);
        step();
        checkFetch("fetch0", 32'h0040_0000);
        step();
        checkFetch("fetch1", 32'h0040_0004);
        step();
        checkFetch("fetch2", 32'h0040_0008);
        checkOutput("pre-stall imem_adrs", {23'd0, bus.imem_adrs}, 32'h003);

        // Four stalled cycles freeze everything
        applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            checkFetch("stall", 32'h0040_0008);
            checkOutput("stall imem_adrs", {23'd0, bus.imem_adrs}, 32'h003);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        step();
        checkFetch("post-stall", 32'h0040_000C);

        // Redirect wins over stall and drops the low address bits
        applyStimulus(1'b1, 1'b1, 32'h0040_0343, 1'b0);
        step();
        checkOutput("redirect if_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("redirect if_instr", bus.if_instr, 32'd0);
        checkOutput("redirect imem_adrs", {23'd0, bus.imem_adrs}, 32'h0D0);
        checkOutput("redirect if_pc held", bus.if_pc, 32'h0040_000C);
        checkOutput("redirect if_pc4 held", bus.if_pc4, 32'h0040_0010);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        step();
        checkFetch("redirect target", 32'h0040_0340);

        // Asynchronous reset between edges while running at 0x004000F0
        applyStimulus(1'b0, 1'b1, 32'h0040_00F0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("pc F0 imem_adrs", {23'd0, bus.imem_adrs}, 32'h03C);
        #3 rst = 1'b1;
        #1;
        checkReset("async reset");
        step();
        rst = 1'b0;
        step();
        checkOutput("reboot if_valid", {31'd0, bus.if_valid}, 32'd0);
        step();
        checkFetch("refetch0", 32'h0040_0000);

        // Address wrap at the top of the 32-bit space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("wrap imem_adrs top", {23'd0, bus.imem_adrs}, 32'h1FF);
        step();
        checkOutput("wrap if_pc", bus.if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap if_pc4", bus.if_pc4, 32'h0000_0000);
        checkOutput("wrap if_instr", bus.if_instr, rom_word(9'h1FF));
        checkOutput("wrap imem_adrs next", {23'd0, bus.imem_adrs}, 32'h000);
        step();
        checkFetch("after wrap", 32'h0000_0000);

        // Halt beats a simultaneous redirect, then ignores everything
        applyStimulus(1'b0, 1'b1, 32'h0040_0100, 1'b1);
        step();
        checkOutput("halt if_valid", {31'd0, bus.if_valid}, 32'd0);
        checkOutput("halt if_instr", bus.if_instr, 32'd0);
        checkOutput("halt imem_adrs", {23'd0, bus.imem_adrs}, 32'h001);
        checkOutput("halt if_pc held", bus.if_pc, 32'h0000_0000);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(logic'(i % 2), logic'((i + 1) % 2), 32'h0040_0200, 1'b0);
            step();
            checkOutput("halted if_valid", {31'd0, bus.if_valid}, 32'd0);
            checkOutput("halted imem_adrs", {23'd0, bus.imem_adrs}, 32'h001);
            checkOutput("halted if_instr", bus.if_instr, 32'd0);
        end

        // Only reset leaves HALT
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkReset("halt reset");
        step();
        rst = 1'b0;
        step();
        checkOutput("halt reboot if_valid", {31'd0, bus.if_valid}, 32'd0);
        step();
        checkFetch("halt refetch0", 32'h0040_0000);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, 32'h0040_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, 32'h0000_0000, instruction word driven on bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  downstream not ready; hold fetch state and outputs.
REQ-006 redirect  input  1  taken branch/jump from execute; load redirect_pc.
REQ-007 redirect_pc  input  32  branch/jump target byte address.
REQ-008 halt  input  1  stop fetching (program-exit syscall decoded downstream).
REQ-009 imem_adrs  output  9  word address to instruction ROM, equal to pc[10:2].
REQ-010 imem_dout  input  32  ROM data, combinational from imem_adrs in the same cycle.
REQ-011 if_instr  output  32  registered instruction for decode.
REQ-012 if_pc  output  32  registered byte address of if_instr.
REQ-013 if_pc4  output  32  registered if_pc + 4, for link/branch base.
REQ-014 if_valid  output  1  if_instr/if_pc/if_pc4 hold a real instruction.

Function
REQ-015 The block SHALL hold an internal 32-bit pc register and a 2-bit state register with states BOOT, RUN, HALT.
REQ-016 imem_adrs SHALL be combinational from pc only, with no dependence on stall, redirect or halt in the same cycle.
REQ-017 BOOT SHALL last exactly one cycle after rst deasserts, holding pc and leaving if_valid=0, then SHALL go to RUN unconditionally.
REQ-018 In RUN, the priority SHALL be halt > redirect > stall > normal fetch.
REQ-019 Normal fetch (RUN, no halt/redirect/stall) SHALL load if_instr<=imem_dout, if_pc<=pc, if_pc4<=pc+4, if_valid<=1 and pc<=pc+4.
REQ-020 Redirect SHALL load pc<={redirect_pc[31:2],2'b00}, if_instr<=NOP_WORD, if_valid<=0, and leave if_pc/if_pc4 unchanged; the wrong-path word on imem_dout is discarded.
REQ-021 Redirect SHALL take effect even when stall is high in the same cycle.
REQ-022 Stall alone SHALL hold pc, if_instr, if_pc, if_pc4 and if_valid unchanged.
REQ-023 halt in RUN SHALL move to HALT with if_valid<=0, if_instr<=NOP_WORD and pc frozen, regardless of redirect or stall.
REQ-024 HALT SHALL be exited only by rst; in HALT, all inputs other than rst SHALL be ignored.
REQ-025 pc+4 and if_pc4 SHALL wrap modulo 2^32; imem_adrs SHALL wrap naturally at 512 words (pc[10:2]), with no error indication.
REQ-026 Fetch-to-if_valid latency SHALL be one cycle; the first valid instruction SHALL appear on the second rising edge after rst deasserts.

Reset
REQ-027 While rst=1: pc=RESET_PC, state=BOOT, if_instr=NOP_WORD, if_pc=0, if_pc4=0, if_valid=0, imem_adrs=RESET_PC[10:2].
REQ-028 rst asserted mid-operation, including during stall, redirect or HALT, SHALL apply REQ-027 immediately without waiting for a clock edge.

Verification
REQ-029 Release rst with the ROM model attached, no stall -> edge 1: if_valid=0; edge 2: if_pc=0x00400000, if_instr=ROM[0]; edge 3: if_pc=0x00400004, if_instr=ROM[1].
REQ-030 After 3 valid fetches, hold stall=1 for 4 cycles -> outputs and imem_adrs frozen; after release the next if_pc=previous+4 with no skipped or duplicated word.
REQ-031 redirect=1 with stall=1 and redirect_pc=0x00400343 -> next edge: if_valid=0, if_instr=0, imem_adrs=0x0D0; following edge: if_pc=0x00400340, if_instr=ROM[0x0D0].
REQ-032 halt=1 with redirect=1 in the same cycle -> HALT entered, if_valid=0, pc unchanged; subsequent redirect/stall toggling has no effect for 10 cycles.
REQ-033 Assert rst asynchronously between edges while in RUN at pc=0x004000F0 -> outputs take reset values before the next edge; fetch restarts at 0x00400000.
REQ-034 Preload pc near wrap via redirect_pc=0xFFFFFFFC -> fetched if_pc=0xFFFFFFFC, if_pc4=0x00000000, next imem_adrs=0x000.
